// File: rtl/reset_sequencer.sv
// Purpose: power-on / software reset sequencer driving N thermometer-coded active-low domain resets.
// Latency: rstn_o[0] releases SYNC_STAGES+1+STRETCH_CYCLES edges after arstn_i rises, then one domain per STEP_CYCLES.
// Backpressure: none; sw_rst_req_i is a level honoured only in RUN, answered by a one-cycle sw_rst_ack_o pulse.
//
// Ports:
//   clk_i         shared clock for all domains
//   arstn_i       board-level async active-low reset (assert async, release synchronised here)
//   sw_rst_req_i  software reset request level, synchronous to clk_i
//   sw_rst_ack_o  one-cycle pulse when the software reset hold ends and re-release begins
//   rstn_o        per-domain active-low resets, bit 0 released first and asserted last
//   ready_o       high only while every domain is released (RUN)
//   state_o       current FSM state: 0 RESET, 1 STRETCH, 2 RELEASE, 3 RUN, 4 ASSERT, 5 HOLD

module reset_sequencer #(
   parameter int N_DOMAINS      = 4,
   parameter int SYNC_STAGES    = 2,
   parameter int STRETCH_CYCLES = 16,
   parameter int STEP_CYCLES    = 8
) (
   input  logic                 clk_i,
   input  logic                 arstn_i,
   input  logic                 sw_rst_req_i,
   output logic                 sw_rst_ack_o,
   output logic [N_DOMAINS-1:0] rstn_o,
   output logic                 ready_o,
   output logic [2:0]           state_o
);

   localparam int MAX_CYCLES = (STRETCH_CYCLES > STEP_CYCLES) ? STRETCH_CYCLES : STEP_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);

   // Counter reload values: a phase of L cycles counts L-1 down to 0 and acts on the edge that sees 0.
   localparam logic [CW-1:0] STRETCH_LOAD = CW'(STRETCH_CYCLES - 1);
   localparam logic [CW-1:0] STEP_LOAD    = CW'(STEP_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE      = CW'(1);

   typedef enum logic [2:0] {
      ST_RESET   = 3'd0,
      ST_STRETCH = 3'd1,
      ST_RELEASE = 3'd2,
      ST_RUN     = 3'd3,
      ST_ASSERT  = 3'd4,
      ST_HOLD    = 3'd5
   } state_t;

   state_t                 state;
   logic [CW-1:0]          cnt;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   arstn_sync;
   logic [N_DOMAINS-1:0]   rel_nxt;
   logic [N_DOMAINS-1:0]   asrt_nxt;

   // Release synchroniser: clears asynchronously with arstn_i, then shifts ones in so
   // arstn_sync rises on the SYNC_STAGES-th edge after arstn_i goes high.
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
      end
   end

   assign arstn_sync = sync_q[SYNC_STAGES-1];

   // rstn_o is kept thermometer-coded, so releasing the next domain is a shift-in of a one
   // at the bottom and asserting the highest released domain is a logical shift right.
   // Both forms work unchanged for a single domain.
   always_comb begin
      rel_nxt    = rstn_o << 1;
      rel_nxt[0] = 1'b1;
      asrt_nxt   = rstn_o >> 1;
   end

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         state        <= ST_RESET;
         cnt          <= '0;
         rstn_o       <= '0;
         ready_o      <= 1'b0;
         sw_rst_ack_o <= 1'b0;
      end else begin
         sw_rst_ack_o <= 1'b0;
         case (state)
            ST_RESET: begin
               if (arstn_sync) begin
                  state <= ST_STRETCH;
                  cnt   <= STRETCH_LOAD;
               end
            end

            // All domains held; the edge that sees the counter at zero releases domain 0.
            ST_STRETCH: begin
               if (cnt == '0) begin
                  rstn_o <= rel_nxt;
                  state  <= ST_RELEASE;
                  cnt    <= STEP_LOAD;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end

            // Once the top domain is out of reset, spend exactly one more edge before RUN.
            ST_RELEASE: begin
               if (rstn_o[N_DOMAINS-1]) begin
                  state   <= ST_RUN;
                  ready_o <= 1'b1;
               end else if (cnt == '0) begin
                  rstn_o <= rel_nxt;
                  cnt    <= STEP_LOAD;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end

            // The request edge itself asserts the top domain; with one domain that is
            // already the last one, so the sequence goes straight to HOLD.
            ST_RUN: begin
               if (sw_rst_req_i) begin
                  ready_o <= 1'b0;
                  rstn_o  <= asrt_nxt;
                  cnt     <= STEP_LOAD;
                  state   <= (asrt_nxt == '0) ? ST_HOLD : ST_ASSERT;
               end
            end

            ST_ASSERT: begin
               if (cnt == '0) begin
                  rstn_o <= asrt_nxt;
                  cnt    <= STEP_LOAD;
                  if (asrt_nxt == '0) begin
                     state <= ST_HOLD;
                  end
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end

            // Every domain in reset for STEP_CYCLES; the closing edge acknowledges and
            // re-enters the same stretch/release path used after power-on.
            ST_HOLD: begin
               if (cnt == '0) begin
                  sw_rst_ack_o <= 1'b1;
                  state        <= ST_STRETCH;
                  cnt          <= STRETCH_LOAD;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end

            default: begin
               state   <= ST_RESET;
               cnt     <= '0;
               rstn_o  <= '0;
               ready_o <= 1'b0;
            end
         endcase
      end
   end

   assign state_o = state;

endmodule
